image_buffer_pp: RTL and testbench
==================================

# image_buffer_pp

Double-buffered (ping-pong) frame store for the detection pipeline. It holds up to two frames of IMG_WIDTH×IMG_HEIGHT pixels, so frame N+1 can stream in while the classifier stages read frame N. Reads go through N_RD independent address/data ports, one per parallel feature evaluator, and each port has its own skid-free one-deep output register. It replaces the single-bank image buffer, which had to finish one frame before it could accept the next.

## Interface
- W_DATA, 8, pixel width in bits
- IMG_WIDTH, 45, frame width in pixels
- IMG_HEIGHT, 45, frame height in pixels
- N_RD, 2, number of read ports (≥1)
- DEPTH (local), IMG_WIDTH*IMG_HEIGHT, words per bank
- W_ADDR (local), $clog2(DEPTH), read address width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- din_valid  in  1  write beat valid
- din_ready  out  1  write bank free, beat accepted when valid&ready
- din_data  in  W_DATA  pixel, raster order
- din_eot  in  1  qualifies the final beat of a frame
- addr_valid  in  N_RD  per-port read request
- addr_ready  out  N_RD  per-port request accept
- addr_data  in  N_RD*W_ADDR  per-port address, port i at [i*W_ADDR +: W_ADDR]
- dout_valid  out  N_RD  per-port read data valid
- dout_ready  in  N_RD  per-port read data accept
- dout_data  out  N_RD*W_DATA  per-port data, port i at [i*W_DATA +: W_DATA]
- rd_done  in  1  single-cycle pulse: the consumer has released the current read frame
- frame_avail  out  1  read bank holds a loaded frame
- both_full  out  1  both banks loaded, writer stalled
- ovf  out  1  sticky: a frame hit DEPTH beats without din_eot

## Operation
- Storage: two banks of DEPTH words. Each bank has a state bit, FREE or LOADED. wr_sel and rd_sel select the write and read banks.
- Write: din_ready = (bank[wr_sel]==FREE). Each accepted beat stores to bank[wr_sel][wr_cnt], and wr_cnt increments.
- A frame closes on the first of two events:
  - an accepted beat with din_eot=1;
  - the DEPTH-th accepted beat. If that beat has din_eot=0, ovf is set.
- On close: bank[wr_sel] becomes LOADED, wr_sel toggles, wr_cnt returns to 0.
- Short frames (eot before DEPTH) are legal. Unwritten words keep stale contents.
- Read: frame_avail = (bank[rd_sel]==LOADED).
- Per port i: addr_ready[i] = frame_avail & (!dout_valid[i] | dout_ready[i]).
- Address handshake: the next cycle, dout_data[i] = bank[rd_sel][addr], and dout_valid[i] is set.
- dout_valid[i] clears on dout_ready[i] unless a new address handshake happens in the same cycle.
- Any address ≥ DEPTH returns 0.
- All ports may read the same or different addresses in the same cycle without conflict. Replicating the memory per port is an acceptable implementation.
- rd_done with frame_avail=1: bank[rd_sel] becomes FREE and rd_sel toggles. With frame_avail=0 it is ignored.
- both_full = both banks LOADED.
- ovf clears only on rst.

## Timing
- Reset values: din_ready=1, addr_ready=0, dout_valid=0, dout_data=0, frame_avail=0, both_full=0, ovf=0, wr_sel=rd_sel=0, wr_cnt=0, both banks FREE. Beats presented during rst are discarded.
- Read latency is 1 cycle from address handshake to dout_valid. A port sustains 1 read per cycle while dout_ready=1.
- Closing beat at cycle t: frame_avail=1 at t+1 if that bank is the read bank. din_ready at t+1 reflects the other bank's state.
- rd_done at cycle t: the released bank is FREE at t+1. addr_ready follows the new rd_sel bank at t+1.
- Data captured before rd_done stays valid in the dout register until accepted.
- A closing write beat and rd_done in the same cycle both take effect. The writer may close into bank X while the reader frees bank Y, and final states are consistent.
- Writing into a bank freed at cycle t is allowed from t+1. The freed bank's earlier data is never returned after t.
- Mid-frame rst aborts the partial frame and discards loaded frames. No port outputs data the cycle after rst.

## Test plan
- Basic: load a 45×45 ramp (pixel = addr mod 256) ending with eot. Port 0 reads addr 0, 1, 2024 -> dout 0, 1, 232, each 1 cycle after its handshake. frame_avail=1 one cycle after the eot beat.
- Ping-pong: load frame A (all 0x11) then frame B (all 0x22) without rd_done. both_full=1 and din_ready=0. Reads return 0x11. rd_done -> reads return 0x22, din_ready=1 the next cycle.
- Multi-port backpressure: N_RD=2, both ports issue reads every cycle, port 1 holds dout_ready=0 for 3 cycles. Port 1 keeps its data stable and addr_ready[1]=0 while stalled. Port 0 streams unaffected.
- Boundaries: read addr 2025 -> 0. A 10-beat frame with eot is then readable at addr 0–9. A 2025-beat frame without eot closes automatically and sets ovf=1.
- Simultaneous events: final beat of frame B and rd_done for frame A in the same cycle -> next cycle rd_sel=B, frame_avail=1, din_ready=1.
- Reset mid-operation: assert rst after 100 beats of frame A, then send a fresh frame with pixel = addr + 1. Reads return the new frame's values, with no stale frame_avail or dout_valid.

Source files
------------

// File: rtl/image_buffer_pp.sv
// ============================================================================
// image_buffer_pp : ping-pong frame store, one raster writer, N_RD read ports
// Rev 1.0
// ============================================================================
`default_nettype none

module image_buffer_pp #(
   parameter  int W_DATA     = 8,
   parameter  int IMG_WIDTH  = 45,
   parameter  int IMG_HEIGHT = 45,
   parameter  int N_RD       = 2,
   localparam int DEPTH      = IMG_WIDTH * IMG_HEIGHT,
   localparam int W_ADDR     = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     din_valid,
   output logic                     din_ready,
   input  logic [W_DATA-1:0]        din_data,
   input  logic                     din_eot,
   input  logic [N_RD-1:0]          addr_valid,
   output logic [N_RD-1:0]          addr_ready,
   input  logic [N_RD*W_ADDR-1:0]   addr_data,
   output logic [N_RD-1:0]          dout_valid,
   input  logic [N_RD-1:0]          dout_ready,
   output logic [N_RD*W_DATA-1:0]   dout_data,
   input  logic                     rd_done,
   output logic                     frame_avail,
   output logic                     both_full,
   output logic                     ovf
);

   typedef enum logic {
      BANK_FREE   = 1'b0,
      BANK_LOADED = 1'b1
   } bank_state_t;

   localparam logic [W_ADDR-1:0] c_LAST = W_ADDR'(DEPTH - 1);

   logic [W_DATA-1:0] r_mem [2][DEPTH];
   bank_state_t       r_bank [2];
   logic              r_wr_sel;
   logic              r_rd_sel;
   logic [W_ADDR-1:0] r_wr_cnt;
   logic              r_ovf;

   logic w_wr_fire;
   logic w_close;
   logic w_release;

   assign din_ready   = (r_bank[r_wr_sel] == BANK_FREE);
   assign frame_avail = (r_bank[r_rd_sel] == BANK_LOADED);
   assign both_full   = (r_bank[0] == BANK_LOADED) && (r_bank[1] == BANK_LOADED);
   assign ovf         = r_ovf;

   assign w_wr_fire = din_valid & din_ready;
   assign w_close   = w_wr_fire & (din_eot | (r_wr_cnt == c_LAST));
   assign w_release = rd_done & frame_avail;

   always_ff @(posedge clk) begin
      if (w_wr_fire && !rst) begin
         r_mem[r_wr_sel][r_wr_cnt] <= din_data;
      end
   end

   // A close always targets a FREE bank and a release a LOADED one, so the two
   // bank-state updates below can never hit the same entry in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bank[0] <= BANK_FREE;
         r_bank[1] <= BANK_FREE;
         r_wr_sel  <= 1'b0;
         r_rd_sel  <= 1'b0;
         r_wr_cnt  <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_close) begin
            r_bank[r_wr_sel] <= BANK_LOADED;
            r_wr_sel         <= ~r_wr_sel;
            r_wr_cnt         <= '0;
            if (!din_eot) begin
               r_ovf <= 1'b1;
            end
         end else if (w_wr_fire) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
         end
         if (w_release) begin
            r_bank[r_rd_sel] <= BANK_FREE;
            r_rd_sel         <= ~r_rd_sel;
         end
      end
   end

   for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
      logic [W_ADDR-1:0] w_addr;
      logic              w_hs;
      logic              r_valid;
      logic [W_DATA-1:0] r_data;

      assign w_addr         = addr_data[gi*W_ADDR +: W_ADDR];
      assign addr_ready[gi] = frame_avail & (~r_valid | dout_ready[gi]);
      assign w_hs           = addr_valid[gi] & addr_ready[gi];
      assign dout_valid[gi] = r_valid;
      assign dout_data[gi*W_DATA +: W_DATA] = r_data;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
         end else if (w_hs) begin
            r_valid <= 1'b1;
            r_data  <= (w_addr <= c_LAST) ? r_mem[r_rd_sel][w_addr] : '0;
         end else if (dout_ready[gi]) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_image_buffer_pp.sv
// ============================================================================
// tb_image_buffer_pp : scoreboard bench for the ping-pong frame store
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_image_buffer_pp;

   localparam int W_ADDR = 11;
   localparam int DEPTH  = 2025;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        din_valid = 1'b0;
   logic        din_ready;
   logic [7:0]  din_data = '0;
   logic        din_eot = 1'b0;
   logic [1:0]  addr_valid = '0;
   logic [1:0]  addr_ready;
   logic [21:0] addr_data = '0;
   logic [1:0]  dout_valid;
   logic [1:0]  dout_ready = 2'b11;
   logic [15:0] dout_data;
   logic        rd_done = 1'b0;
   logic        frame_avail;
   logic        both_full;
   logic        ovf;

   int n_chk  = 0;
   int n_pass = 0;

   image_buffer_pp #(
      .W_DATA(8), .IMG_WIDTH(45), .IMG_HEIGHT(45), .N_RD(2)
   ) dut (
      .clk(clk), .rst(rst),
      .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_eot(din_eot),
      .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_data(addr_data),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
      .rd_done(rd_done), .frame_avail(frame_avail), .both_full(both_full), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // ---------------- reference model + scoreboard ----------------
   logic [7:0] mdl [2][DEPTH];
   bit         m_ld [2];
   bit         m_wr, m_rd, m_ovf;
   int         m_cnt;
   bit         m_v [2];
   logic [7:0] sbq [2][$];

   initial begin
      m_ld[0] = 0; m_ld[1] = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_cnt = 0;
      m_v[0] = 0; m_v[1] = 0;
   end

   always @(negedge clk) begin
      logic [10:0] a;
      bit          rel;
      chk("din_ready", din_ready, !m_ld[m_wr]);
      chk("frame_avail", frame_avail, m_ld[m_rd]);
      chk("both_full", both_full, m_ld[0] & m_ld[1]);
      chk("ovf", ovf, m_ovf);
      for (int p = 0; p < 2; p++) begin
         chk("addr_ready", addr_ready[p], m_ld[m_rd] & (!m_v[p] | dout_ready[p]));
         chk("dout_valid", dout_valid[p], m_v[p]);
         if (m_v[p]) begin
            if (sbq[p].size() == 0) chk("sb_empty", 0, 1);
            else chk("dout_data", dout_data[p*8 +: 8], sbq[p][0]);
         end
      end
      if (rst) begin
         m_ld[0] = 0; m_ld[1] = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_cnt = 0;
         for (int p = 0; p < 2; p++) begin
            m_v[p] = 0;
            sbq[p].delete();
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (m_v[p] && dout_ready[p] && sbq[p].size() > 0) void'(sbq[p].pop_front());
            if (addr_valid[p] && m_ld[m_rd] && (!m_v[p] || dout_ready[p])) begin
               a = addr_data[p*W_ADDR +: W_ADDR];
               sbq[p].push_back((a < DEPTH) ? mdl[m_rd][a] : 8'h00);
               m_v[p] = 1;
            end else if (dout_ready[p]) begin
               m_v[p] = 0;
            end
         end
         rel = rd_done && m_ld[m_rd];
         if (din_valid && !m_ld[m_wr]) begin
            mdl[m_wr][m_cnt] = din_data;
            if (din_eot || m_cnt == DEPTH - 1) begin
               if (!din_eot) m_ovf = 1;
               m_ld[m_wr] = 1;
               m_wr = !m_wr;
               m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end
         if (rel) begin
            m_ld[m_rd] = 0;
            m_rd = !m_rd;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic logic [7:0] pix(input int mode, input logic [7:0] val, input int k);
      logic [31:0] v;
      v = (mode == 0) ? k : (mode == 2) ? k + 1 : 32'(val);
      return v[7:0];
   endfunction

   task automatic send_frame(input int n, input int mode, input logic [7:0] val,
                             input bit eot, input bit rd_last);
      for (int k = 0; k < n; k++) begin
         int t;
         t = 0;
         din_valid = 1'b1;
         din_data  = pix(mode, val, k);
         din_eot   = eot && (k == n - 1);
         rd_done   = rd_last && (k == n - 1);
         @(negedge clk);
         while (!din_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) begin
            chk("din_timeout", 0, 1);
            break;
         end
         tick();
      end
      din_valid = 1'b0;
      din_eot   = 1'b0;
      rd_done   = 1'b0;
   endtask

   task automatic rd(input int p, input int a, input logic [7:0] exp);
      int t;
      t = 0;
      addr_valid[p] = 1'b1;
      addr_data[p*W_ADDR +: W_ADDR] = 11'(a);
      @(negedge clk);
      while (!addr_ready[p] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("rd_timeout", 0, 1);
      tick();
      addr_valid[p] = 1'b0;
      chk("rd_valid", dout_valid[p], 1);
      chk("rd_data", dout_data[p*8 +: 8], exp);
   endtask

   task automatic release_frame();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, n0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_din_ready", din_ready, 1);
      chk("rst_addr_ready", addr_ready, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_dout_data", dout_data, 0);
      chk("rst_frame_avail", frame_avail, 0);
      chk("rst_both_full", both_full, 0);
      chk("rst_ovf", ovf, 0);

      // basic ramp frame
      send_frame(DEPTH, 0, 8'h00, 1, 0);
      chk("basic_avail", frame_avail, 1);
      chk("basic_ovf", ovf, 0);
      rd(0, 0, 8'd0);
      rd(0, 1, 8'd1);
      rd(0, 2024, 8'd232);
      rd(1, 2025, 8'd0);
      release_frame();
      chk("rel_avail", frame_avail, 0);

      // ping-pong
      send_frame(DEPTH, 1, 8'h11, 1, 0);
      send_frame(DEPTH, 1, 8'h22, 1, 0);
      chk("pp_both_full", both_full, 1);
      chk("pp_din_ready", din_ready, 0);
      rd(0, 5, 8'h11);
      rd(1, 2000, 8'h11);
      release_frame();
      chk("pp_din_ready2", din_ready, 1);
      chk("pp_avail", frame_avail, 1);
      rd(0, 5, 8'h22);

      // short frame closing in the same cycle as rd_done
      send_frame(10, 1, 8'h44, 1, 1);
      chk("sim_avail", frame_avail, 1);
      chk("sim_din_ready", din_ready, 1);
      chk("sim_both_full", both_full, 0);
      for (int k = 0; k < 10; k++) rd(k % 2, k, 8'h44);
      rd(0, 10, 8'h11);
      release_frame();

      // frame without eot closes on its own and sets ovf
      send_frame(DEPTH, 0, 8'h00, 0, 0);
      chk("ovf_set", ovf, 1);
      chk("ovf_avail", frame_avail, 1);

      // two ports streaming, port 1 stalled for 3 cycles
      a0 = 0; a1 = 100; n0 = 0;
      for (int c = 0; c < 12; c++) begin
         dout_ready[1] = !(c >= 4 && c < 7);
         addr_valid    = 2'b11;
         addr_data     = {11'(a1), 11'(a0)};
         @(negedge clk);
         if (addr_ready[0]) begin
            a0++;
            n0++;
         end
         if (addr_ready[1]) a1++;
         if (c >= 4 && c < 7) chk("stall_ardy1", addr_ready[1], 0);
         tick();
      end
      addr_valid = 2'b00;
      dout_ready = 2'b11;
      chk("port0_stream", n0, 12);
      chk("port1_count", a1 - 100, 9);
      tick();
      tick();
      release_frame();
      chk("ovf_sticky", ovf, 1);

      // reset mid-frame with a loaded frame and a pending read
      send_frame(10, 1, 8'h55, 1, 0);
      send_frame(100, 1, 8'h66, 0, 0);
      dout_ready = 2'b00;
      addr_valid = 2'b11;
      addr_data  = {11'd3, 11'd3};
      tick();
      addr_valid = 2'b00;
      chk("pre_rst_valid", dout_valid, 2'b11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dout_ready = 2'b11;
      chk("mr_dout_valid", dout_valid, 0);
      chk("mr_avail", frame_avail, 0);
      chk("mr_ovf", ovf, 0);
      chk("mr_din_ready", din_ready, 1);
      send_frame(DEPTH, 2, 8'h00, 1, 0);
      rd(0, 0, 8'd1);
      rd(1, 300, 8'd45);
      rd(0, 2024, 8'd233);
      addr_valid = 2'b11;
      addr_data  = {11'd7, 11'd7};
      tick();
      addr_valid = 2'b00;
      chk("same_addr", dout_data, 16'h0808);
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
